// File: rtl/fetch_pkg.sv
// Shared types for the fetch/decode boundary: the fetched packet layout
// and the canonical NOP used when no packet is presented.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } fetch_packet_t;
endpackage

// File: rtl/fetch_queue_ptr.sv
// Wrap-around read/write pointers and occupancy count for the fetch queue.
// Pointers wrap naturally because DEPTH is a power of two.
module fetch_queue_ptr #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      // simultaneous push and pop leaves the occupancy unchanged
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  a_no_push_full:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_count_bound:   assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode; a flush squashes every buffered
// wrong-path packet and blocks both handshakes for that cycle.
//
// Handshake: a transfer happens on a port exactly when valid && ready are both
// high at a rising clk edge. in_ready never looks at out_ready (no push-through
// when full), and out_valid never looks at in_valid (no bypass when empty).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_pred_taken,
  output logic [XLEN-1:0] out_pred_target,
  output logic [CW-1:0]   count
);

  fetch_packet_t entry [DEPTH];
  fetch_packet_t head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign in_ready  = !full && !flush;
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Storage holds no reset: occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      entry[wr_ptr] <= '{pc: in_pc, instr: in_instr,
                         pred_taken: in_pred_taken, pred_target: in_pred_target};
    end
  end

  assign head            = entry[rd_ptr];
  assign out_pc          = head.pc;
  assign out_instr       = out_valid ? head.instr : NOP_INSTR;
  assign out_pred_taken  = head.pred_taken;
  assign out_pred_target = head.pred_target;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written wrap/reset
// sequences, then random traffic checked against a queue-based model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int W = $bits(fetch_packet_t);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_pred_taken = 1'b0;
  logic [31:0] in_pred_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_pred_taken;
  logic [31:0] out_pred_target;
  logic [2:0]  count;

  fetch_packet_t out_pkt;
  assign out_pkt = {out_pc, out_instr, out_pred_taken, out_pred_target};

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target), .count(count)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // ---- helpers ----
  function automatic fetch_packet_t mk(input logic [31:0] pc);
    fetch_packet_t p;
    p.pc          = pc;
    p.instr       = pc ^ 32'hA5A5_5A5A;
    p.pred_taken  = pc[3];
    p.pred_target = pc + 32'h40;
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic v, input logic r, input logic [31:0] pc);
    fetch_packet_t p;
    p = mk(pc);
    flush = f; in_valid = v; out_ready = r;
    in_pc = p.pc; in_instr = p.instr; in_pred_taken = p.pred_taken; in_pred_target = p.pred_target;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- scoreboard step: model is an ordered list of packets ----
  task automatic step(input logic f, input logic v, input logic r, input logic [31:0] pc);
    logic e_ir, e_ov;
    drive(f, v, r, pc);
    #1;
    e_ir = (exp_q.size() != DEPTH) && !f;
    e_ov = (exp_q.size() != 0) && !f;
    chk("in_ready", in_ready, e_ir);
    chk("out_valid", out_valid, e_ov);
    chk("count", count, exp_q.size());
    if (e_ov) chk("out_pkt", out_pkt, exp_q[0]);
    tick();
    if (f) exp_q.delete();
    else begin
      if (e_ov && r) void'(exp_q.pop_front());
      if (e_ir && v) exp_q.push_back(mk(pc));
    end
  endtask

  // ---- directed vector table ----
  typedef struct {
    logic f, v, r;
    logic [31:0] pc;
    logic ir, ov;
    logic [2:0] cnt;
    logic chk_pc;
    logic [31:0] opc;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic f, v, r, input logic [31:0] pc, input logic ir, ov,
                     input logic [2:0] cnt, input logic cp, input logic [31:0] opc);
    vec_t x;
    x.f = f; x.v = v; x.r = r; x.pc = pc; x.ir = ir; x.ov = ov;
    x.cnt = cnt; x.chk_pc = cp; x.opc = opc;
    vq.push_back(x);
  endtask

  initial begin
    // reset held for two edges, released between edges
    tick(); tick();
    rst = 1'b0;
    #1;

    //   f  v  r  pc          ir ov cnt chk opc
    add(0, 0, 0, 32'h0,      1, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,      1, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h0,      1, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h4,      1, 1, 1, 1, 32'h0);
    add(0, 1, 0, 32'h8,      1, 1, 2, 1, 32'h0);
    add(0, 0, 0, 32'h0,      1, 1, 3, 1, 32'h0);
    add(0, 0, 1, 32'h0,      1, 1, 3, 1, 32'h0);
    add(0, 0, 1, 32'h0,      1, 1, 2, 1, 32'h4);
    add(0, 0, 1, 32'h0,      1, 1, 1, 1, 32'h8);
    add(0, 0, 0, 32'h0,      1, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h10,     1, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h14,     1, 1, 1, 1, 32'h10);
    add(0, 1, 0, 32'h18,     1, 1, 2, 1, 32'h10);
    add(0, 1, 0, 32'h1C,     1, 1, 3, 1, 32'h10);
    add(0, 1, 1, 32'h20,     0, 1, 4, 1, 32'h10);
    add(0, 1, 1, 32'h20,     1, 1, 3, 1, 32'h14);
    add(0, 0, 1, 32'h0,      1, 1, 3, 1, 32'h18);
    add(0, 0, 1, 32'h0,      1, 1, 2, 1, 32'h1C);
    add(0, 0, 1, 32'h0,      1, 1, 1, 1, 32'h20);
    add(0, 0, 0, 32'h0,      1, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h30,     1, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'h34,     1, 1, 1, 1, 32'h30);
    add(0, 1, 0, 32'h38,     1, 1, 2, 1, 32'h30);
    add(1, 1, 1, 32'h3C,     0, 0, 3, 0, 32'h0);
    add(0, 1, 0, 32'h100,    1, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,      1, 1, 1, 1, 32'h100);
    add(1, 0, 0, 32'h0,      0, 0, 1, 0, 32'h0);
    add(1, 1, 1, 32'h200,    0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,      1, 0, 0, 0, 32'h0);

    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_count", count, 3'd0);

    foreach (vq[i]) begin
      drive(vq[i].f, vq[i].v, vq[i].r, vq[i].pc);
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, vq[i].ir);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vq[i].ov);
      chk($sformatf("vec%0d_count", i), count, vq[i].cnt);
      if (vq[i].chk_pc) chk($sformatf("vec%0d_out_pkt", i), out_pkt, mk(vq[i].opc));
      tick();
    end

    // steady push+pop at count 2 across pointer wrap
    exp_q.delete();
    step(0, 1, 0, 32'h200);
    step(0, 1, 0, 32'h204);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 32'h208 + 32'(i) * 4);
      chk("steady_count", count, 3'd2);
    end
    step(0, 0, 1, 32'h0);
    step(0, 0, 1, 32'h0);
    chk("steady_drained", count, 3'd0);

    // asynchronous reset mid-stream
    step(0, 1, 0, 32'h300);
    step(0, 1, 0, 32'h304);
    drive(0, 0, 0, 32'h0);
    #2;
    chk("pre_rst_count", count, 3'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_count", count, 3'd0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    tick();
    step(0, 1, 0, 32'h308);
    drive(0, 0, 0, 32'h0);
    #1;
    chk("post_rst_out_pc", out_pc, 32'h308);
    step(0, 0, 1, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(15) == 0, $urandom_range(9) < 7, $urandom_range(9) < 6,
           $urandom() & 32'hFFFF_FFFC);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
